fb_swap_ctrl: RTL and testbench

Single-clock controller that sequences the double-buffered LCD framebuffer. It generates the scanout read address, accepts renderer pixels with a valid/ready handshake, and generates their write address. Once a complete frame is written, it issues the `switch` pulse that flips the buffers, aligned to the scanout frame boundary so no frame is ever displayed torn. It sits between the renderer, the framebuffer (`rad`, `wad`, `switch`, write data path) and the LCD timing generator (`scan_en`).

---
 rtl/fb_swap_ctrl_if.sv | 42 ++++
 rtl/fb_swap_ctrl.sv | 130 +++++++++++++
 tb/tb_fb_swap_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/fb_swap_ctrl_if.sv
// Renderer / scanout / framebuffer signal bundle for fb_swap_ctrl.
// master: renderer + LCD timing side, slave: the swap controller.
interface fb_swap_ctrl_if #(
   parameter int ADDR_W = 32
);
   logic              scan_en;
   logic [ADDR_W-1:0] rad;
   logic              frame_start;
   logic              wr_valid;
   logic              wr_ready;
   logic              wr_we;
   logic [ADDR_W-1:0] wad;
   logic              wr_frame_done;
   logic              switch;
   logic [7:0]        repeat_cnt;

   modport master (
      output scan_en,
      output wr_valid,
      input  rad,
      input  frame_start,
      input  wr_ready,
      input  wr_we,
      input  wad,
      input  wr_frame_done,
      input  switch,
      input  repeat_cnt
   );

   modport slave (
      input  scan_en,
      input  wr_valid,
      output rad,
      output frame_start,
      output wr_ready,
      output wr_we,
      output wad,
      output wr_frame_done,
      output switch,
      output repeat_cnt
   );
endinterface

// File: rtl/fb_swap_ctrl.sv
// Double-buffered framebuffer sequencer: scanout address, renderer
// write address, and a frame-aligned buffer flip.
module fb_swap_ctrl #(
   parameter int H_ACTIVE = 480,
   parameter int V_ACTIVE = 272,
   parameter int ADDR_W   = 32,
   parameter int SWAP_LEN = 2
) (
   input logic            clk,
   input logic            rst_n,
   fb_swap_ctrl_if.slave  fb
);

   localparam int N = H_ACTIVE * V_ACTIVE;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);
   localparam int CW = (SWAP_LEN > 1) ? $clog2(SWAP_LEN) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(SWAP_LEN - 1);

   typedef enum logic [1:0] {
      FILL = 2'd0,
      FULL = 2'd1,
      SWAP = 2'd2
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [ADDR_W-1:0] rad_q;
   logic [ADDR_W-1:0] wad_q;
   logic [CW-1:0]     cnt_q;
   logic              switch_q;
   logic              done_q;
   logic [7:0]        rep_q;

   logic              frame_end;
   logic              ready;
   logic              accept;
   logic              last_acc;
   logic              swap_entry;

   assign frame_end  = fb.scan_en && (rad_q == LAST);
   assign accept     = fb.wr_valid && ready;
   assign last_acc   = accept && (wad_q == LAST);
   assign swap_entry = (state_q != SWAP) && (state_d == SWAP);

   // Scanout read counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rad_q <= '0;
      end else if (fb.scan_en) begin
         if (rad_q == LAST) rad_q <= '0;
         else               rad_q <= rad_q + ADDR_W'(1);
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= FILL;
      else        state_q <= state_d;
   end

   // FSM next state; a last-pixel accept only reaches FULL, so a
   // coincident frame_end cannot trigger the flip in the same cycle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         FILL: if (last_acc)       state_d = FULL;
         FULL: if (frame_end)      state_d = SWAP;
         SWAP: if (cnt_q == '0)    state_d = FILL;
         default:                  state_d = FILL;
      endcase
   end

   // FSM combinational outputs
   always_comb begin
      ready = (state_q == FILL);
   end

   // Swap length counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (swap_entry) begin
         cnt_q <= CNT_LOAD;
      end else if (state_q == SWAP && cnt_q != '0) begin
         cnt_q <= cnt_q - CW'(1);
      end
   end

   // Registered pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         switch_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         switch_q <= (state_d == SWAP);
         done_q   <= (state_q == SWAP) && (state_d == FILL);
      end
   end

   // Write address; wraps to 0 on the last pixel and holds there
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wad_q <= '0;
      end else if (accept) begin
         if (wad_q == LAST) wad_q <= '0;
         else               wad_q <= wad_q + ADDR_W'(1);
      end
   end

   // Frames shown since last swap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rep_q <= '0;
      end else if (swap_entry) begin
         rep_q <= '0;
      end else if (frame_end && rep_q != 8'hFF) begin
         rep_q <= rep_q + 8'd1;
      end
   end

   assign fb.rad           = rad_q;
   assign fb.frame_start   = fb.scan_en && (rad_q == '0);
   assign fb.wr_ready      = ready;
   assign fb.wr_we         = accept;
   assign fb.wad           = wad_q;
   assign fb.wr_frame_done = done_q;
   assign fb.switch        = switch_q;
   assign fb.repeat_cnt    = rep_q;

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// Bench for fb_swap_ctrl: frame-level reference model plus
// directed timing pins and randomized scan/write traffic.
module tb_fb_swap_ctrl;

   localparam int H  = 4;
   localparam int V  = 2;
   localparam int N  = H * V;
   localparam int SL = 2;
   localparam int AW = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fb_swap_ctrl_if #(.ADDR_W(AW)) fb();

   fb_swap_ctrl #(
      .H_ACTIVE(H),
      .V_ACTIVE(V),
      .ADDR_W(AW),
      .SWAP_LEN(SL)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .fb(fb)
   );

   int errors = 0;
   int checks = 0;

   // Model: pixels written this frame, switch cycles left, frames shown
   int m_rad, m_pix, m_sw, m_rep;
   bit m_done;
   int wr_cnt [N];
   int frames_done;

   logic          s_ready, s_switch, s_done, s_we, s_fs;
   logic [7:0]    s_rep;
   logic [AW-1:0] s_rad, s_wad;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_rad = 0; m_pix = 0; m_sw = 0; m_rep = 0; m_done = 0;
      for (int a = 0; a < N; a++) wr_cnt[a] = 0;
   endtask

   task automatic cycle(input bit scan, input bit valid);
      bit e_ready, e_we, fe, swap_now;
      fb.scan_en  = scan;
      fb.wr_valid = valid;
      @(negedge clk);
      s_ready = fb.wr_ready;  s_switch = fb.switch;
      s_done  = fb.wr_frame_done; s_rep = fb.repeat_cnt;
      s_rad   = fb.rad;       s_wad = fb.wad;
      s_we    = fb.wr_we;     s_fs  = fb.frame_start;
      e_ready = (m_pix < N) && (m_sw == 0);
      e_we    = valid && e_ready;
      chk("rad", s_rad, m_rad);
      chk("wad", s_wad, m_pix % N);
      chk("wr_ready", s_ready, e_ready);
      chk("wr_we", s_we, e_we);
      chk("switch", s_switch, m_sw > 0);
      chk("frame_done", s_done, m_done);
      chk("repeat_cnt", s_rep, m_rep);
      chk("frame_start", s_fs, scan && m_rad == 0);
      if (s_we === 1'b1 && s_wad < N) begin
         chk("wr_once", wr_cnt[s_wad], 0);
         wr_cnt[s_wad]++;
      end
      @(posedge clk);
      fe       = scan && (m_rad == N - 1);
      swap_now = (m_pix == N) && (m_sw == 0) && fe;
      m_done   = (m_sw == 1);
      if (swap_now)               m_rep = 0;
      else if (fe && m_rep < 255) m_rep++;
      if (m_sw > 0) begin
         m_sw--;
         if (m_sw == 0) begin
            m_pix = 0;
            for (int a = 0; a < N; a++) wr_cnt[a] = 0;
         end
      end else if (swap_now) begin
         m_sw = SL;
      end else if (e_we) begin
         m_pix++;
         if (m_pix == N) begin
            frames_done++;
            for (int a = 0; a < N; a++)
               chk("frame_cover", wr_cnt[a], 1);
         end
      end
      if (scan) m_rad = (m_rad + 1) % N;
      #1;
   endtask

   // Asynchronous reset away from the clock edge
   task automatic do_reset();
      fb.scan_en  = 1'b0;
      fb.wr_valid = 1'b0;
      rst_n = 1'b0;
      #2;
      chk("rst_rad", fb.rad, 0);
      chk("rst_wad", fb.wad, 0);
      chk("rst_switch", fb.switch, 0);
      chk("rst_ready", fb.wr_ready, 1);
      chk("rst_done", fb.wr_frame_done, 0);
      chk("rst_rep", fb.repeat_cnt, 0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      frames_done = 0;
      fb.scan_en  = 1'b0;
      fb.wr_valid = 1'b0;
      model_reset();
      #12;
      chk("init_rad", fb.rad, 0);
      chk("init_ready", fb.wr_ready, 1);
      chk("init_we", fb.wr_we, 0);
      chk("init_fs", fb.frame_start, 0);
      fb.scan_en  = 1'b1;
      fb.wr_valid = 1'b1;
      #1;
      chk("rst_we_follow", fb.wr_we, 1);
      chk("rst_fs_follow", fb.frame_start, 1);
      do_reset();

      // Coincident: 8th accept lands on frame_end
      for (int i = 0; i < 20; i++) begin
         cycle(1'b1, i < 8);
         if (i == 8)  chk("co_ready8", s_ready, 0);
         if (i == 8)  chk("co_rep8", s_rep, 1);
         if (i == 15) chk("co_sw15", s_switch, 0);
         if (i == 16) chk("co_sw16", s_switch, 1);
         if (i == 16) chk("co_rep16", s_rep, 0);
         if (i == 17) chk("co_sw17", s_switch, 1);
         if (i == 18) chk("co_sw18", s_switch, 0);
         if (i == 18) chk("co_done18", s_done, 1);
         if (i == 18) chk("co_ready18", s_ready, 1);
      end

      // Plain fill then swap at the next frame boundary
      do_reset();
      for (int i = 0; i < 20; i++) begin
         cycle(1'b1, i >= 1 && i <= 8);
         if (i == 8)  chk("fs_wad8", s_wad, 7);
         if (i == 9)  chk("fs_ready9", s_ready, 0);
         if (i == 16) chk("fs_sw16", s_switch, 1);
         if (i == 16) chk("fs_rad16", s_rad, 0);
         if (i == 18) chk("fs_done18", s_done, 1);
         if (i == 18) chk("fs_rep18", s_rep, 0);
      end

      // Stalled scanout
      do_reset();
      repeat (3) cycle(1'b1, 1'b0);
      for (int i = 0; i < 100; i++) cycle(1'b0, i < 8);
      chk("st_rad", s_rad, 3);
      chk("st_ready", s_ready, 0);
      chk("st_sw", s_switch, 0);
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 1'b0);
         if (i == 5) chk("st_sw5", s_switch, 1);
      end

      // Saturation, no writes
      do_reset();
      repeat (300 * N + 1) cycle(1'b1, 1'b0);
      chk("sat_rep", s_rep, 255);

      // Reset while switch is high
      do_reset();
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1);
      begin
         int k = 0;
         while (s_switch !== 1'b1 && k < 50) begin
            cycle(1'b1, 1'b0);
            k++;
         end
      end
      chk("mid_swap_seen", s_switch, 1);
      do_reset();

      // Partial frame discarded by reset
      repeat (3) cycle(1'b1, 1'b1);
      chk("part_wad", s_wad, 2);
      do_reset();

      // Gappy writer, stuttering scanout
      for (int i = 0; i < 4000; i++)
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
      chk("gap_frames", frames_done > 20, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
